// File: rtl/c2c_master_ctrl.sv
// Chip-to-chip master handshake controller.
// Sends one byte to a slave board with a four-phase request/ack handshake,
// then lights a notice LED for ONE_SEC cycles. Any ack phase that takes
// longer than ACK_TIMEOUT cycles aborts the transfer and sets a sticky err.
//
// Handshake semantics (slave side):
//   request=1 : master has a byte ready and waits for ack to rise.
//   valid=1   : data_out is stable; the slave may sample it until it drops ack.
//   The master never changes data_out while busy=1; request, valid and
//   notice_led are mutually exclusive because each is owned by one state.
module c2c_master_ctrl #(
    parameter int ONE_SEC     = 100000000,
    parameter int ACK_TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic       ack,
    output logic       request,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       notice_led,
    output logic       busy,
    output logic       err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_REL = 2'd2,
        LED_HOLD = 2'd3
    } state_t;

    localparam logic [26:0] ONE_SEC_LAST = 27'(ONE_SEC - 1);
    localparam logic [26:0] ACK_TO_LAST  = 27'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic        ack_meta_q, ack_meta_d;
    logic        ack_s_q, ack_s_d;
    logic        request_q, request_d;
    logic        valid_q, valid_d;
    logic        led_q, led_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;

    // Next-state, counter and registered-output decode.
    always_comb begin
        ack_meta_d = ack;
        ack_s_d    = ack_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (send) begin
                    data_d  = data_in;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Exit is tested before timeout so it wins a same-cycle tie.
                if (ack_s_q) begin
                    cnt_d   = '0;
                    state_d = WAIT_REL;
                end else if (cnt_q == ACK_TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            WAIT_REL: begin
                if (!ack_s_q) begin
                    cnt_d   = '0;
                    state_d = LED_HOLD;
                end else if (cnt_q == ACK_TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            LED_HOLD: begin
                if (cnt_q == ONE_SEC_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Each handshake output is owned by exactly one state, so they can
        // never overlap and always track the state that follows this edge.
        request_d = (state_d == WAIT_ACK);
        valid_d   = (state_d == WAIT_REL);
        led_d     = (state_d == LED_HOLD);
    end

    // State, counter, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            led_q      <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            request_q  <= request_d;
            valid_q    <= valid_d;
            led_q      <= led_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

    assign request    = request_q;
    assign valid      = valid_q;
    assign notice_led = led_q;
    assign err        = err_q;
    assign data_out   = data_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_c2c_master_ctrl.sv
// Testbench for c2c_master_ctrl: directed vector table, random transfers
// against a transfer-level model, and hand-written reset/glitch sequences.
module tb_c2c_master_ctrl;

    localparam int ONE_SEC     = 10;
    localparam int ACK_TIMEOUT = 20;
    localparam int XFER_CYCLES = 80;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] data_in;
    logic       ack;
    logic       request;
    logic [7:0] data_out;
    logic       valid;
    logic       notice_led;
    logic       busy;
    logic       err;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    c2c_master_ctrl #(
        .ONE_SEC     (ONE_SEC),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .send       (send),
        .data_in    (data_in),
        .ack        (ack),
        .request    (request),
        .data_out   (data_out),
        .valid      (valid),
        .notice_led (notice_led),
        .busy       (busy),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // One transfer: send in cycle 0; ack high in cycles [a, a+h) (a=0: never).
    // send2 >= 0 issues a second send with data2 in that cycle.
    typedef struct {
        logic [7:0] data;
        int         a;
        int         h;
        int         send2;
        logic [7:0] data2;
        int         exp_req;
        int         exp_val;
        int         exp_led;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transfer-level reference. The controller sees ack two cycles late and
    // acts on the following edge; request rises in cycle 1. Each wait phase
    // lasts at most ACK_TIMEOUT cycles, with a same-cycle exit taking priority.
    function automatic void model(input int a, input int h,
                                  output int r, output int v, output int l,
                                  output logic e);
        if (a == 0 || a + 2 > ACK_TIMEOUT) begin
            r = ACK_TIMEOUT; v = 0; l = 0; e = 1'b1;
        end else begin
            r = a + 2;
            if (h > ACK_TIMEOUT) begin
                v = ACK_TIMEOUT; l = 0; e = 1'b1;
            end else begin
                v = h; l = ONE_SEC; e = 1'b0;
            end
        end
    endfunction

    function automatic vec_t mk(input logic [7:0] d, input int a, input int h,
                                input int s2, input logic [7:0] d2,
                                input int r, input int v, input int l, input logic e);
        vec_t t;
        t.data = d; t.a = a; t.h = h; t.send2 = s2; t.data2 = d2;
        t.exp_req = r; t.exp_val = v; t.exp_led = l; t.exp_err = e;
        return t;
    endfunction

    // Quiet cycles with all inputs low so the synchronizer drains.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            send = 1'b0; ack = 1'b0;
        end
    endtask

    // Drive one transfer cycle by cycle; sample each cycle at the negedge.
    task automatic run_xfer(input vec_t t, input string tag);
        int n_req, n_val, n_led, first_req, overlap, busy_bad, data_bad;
        logic err_c1;
        n_req = 0; n_val = 0; n_led = 0; first_req = -1;
        overlap = 0; busy_bad = 0; data_bad = 0; err_c1 = 1'bx;
        for (int c = 0; c < XFER_CYCLES; c++) begin
            @(posedge clk); #1;
            send    = (c == 0) || (c == t.send2);
            data_in = (c == 0) ? t.data : t.data2;
            ack     = (t.a != 0) && (c >= t.a) && (c < t.a + t.h);
            @(negedge clk);
            if (request) begin
                n_req++;
                if (first_req < 0) first_req = c;
            end
            if (valid) n_val++;
            if (notice_led) n_led++;
            if (int'(request) + int'(valid) + int'(notice_led) > 1) overlap++;
            if (busy !== (request | valid | notice_led)) busy_bad++;
            if (c >= 1 && data_out !== t.data) data_bad++;
            if (c == 1) err_c1 = err;
        end
        send = 1'b0; ack = 1'b0;
        check({tag, " req_first"}, first_req, 1);
        check({tag, " req_cycles"}, n_req, t.exp_req);
        check({tag, " valid_cycles"}, n_val, t.exp_val);
        check({tag, " led_cycles"}, n_led, t.exp_led);
        check({tag, " err_cleared"}, err_c1, 0);
        check({tag, " err_end"}, err, t.exp_err);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " data_out"}, data_out, t.data);
        check({tag, " overlap"}, overlap, 0);
        check({tag, " busy_decode"}, busy_bad, 0);
        check({tag, " data_hold"}, data_bad, 0);
    endtask

    initial begin
        int   r, v, l;
        logic e;
        int   n_act;
        vec_t t;

        // Reset: send and ack active during reset must have no effect.
        rst_n = 1'b0; send = 1'b1; data_in = 8'hFF; ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst request", request, 0);
        check("rst valid", valid, 0);
        check("rst led", notice_led, 0);
        check("rst busy", busy, 0);
        check("rst err", err, 0);
        check("rst data_out", data_out, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1; send = 1'b0; ack = 1'b0;
        idle(4);
        @(negedge clk);
        check("post_rst busy", busy, 0);

        // Directed vectors.
        vecs.push_back(mk(8'hA5, 4, 7, -1, 8'h00, 6, 7, ONE_SEC, 1'b0));     // nominal
        vecs.push_back(mk(8'h11, 0, 0, -1, 8'h00, 20, 0, 0, 1'b1));          // ack timeout
        vecs.push_back(mk(8'h22, 3, 2, -1, 8'h00, 5, 2, ONE_SEC, 1'b0));     // new send clears err
        vecs.push_back(mk(8'h33, 4, 60, -1, 8'h00, 6, 20, 0, 1'b1));         // release timeout
        vecs.push_back(mk(8'hA5, 4, 7, 9, 8'h3C, 6, 7, ONE_SEC, 1'b0));      // send while busy
        vecs.push_back(mk(8'h44, 18, 20, -1, 8'h00, 20, 20, ONE_SEC, 1'b0)); // both exits tie timeout
        vecs.push_back(mk(8'h55, 19, 3, -1, 8'h00, 20, 0, 0, 1'b1));         // ack one cycle too late
        vecs.push_back(mk(8'h66, 2, 21, -1, 8'h00, 4, 20, 0, 1'b1));         // release one cycle too late
        vecs.push_back(mk(8'h77, 1, 1, -1, 8'h00, 3, 1, ONE_SEC, 1'b0));     // shortest handshake

        foreach (vecs[i]) begin
            idle(4);
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Random transfers against the model.
        for (int k = 0; k < 12; k++) begin
            t.data  = 8'($urandom_range(0, 255));
            t.a     = $urandom_range(0, 22);
            t.h     = (t.a == 0) ? 0 : $urandom_range(1, 23);
            t.data2 = 8'($urandom_range(0, 255));
            model(t.a, t.h, r, v, l, e);
            t.exp_req = r; t.exp_val = v; t.exp_led = l; t.exp_err = e;
            // A second send only while the request phase is certainly active.
            t.send2 = ($urandom_range(0, 1) == 1) ? $urandom_range(2, r) : -1;
            idle(4);
            run_xfer(t, $sformatf("rnd%0d", k));
        end

        // Reset during LED_HOLD (nominal: LED spans cycles 14..23).
        idle(4);
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            send    = (c == 0);
            data_in = 8'hA5;
            ack     = (c >= 4) && (c < 11);
            if (c == 17) begin
                rst_n = 1'b0; send = 1'b1; data_in = 8'h3C;
            end
            @(negedge clk);
            if (c == 16) check("midrst led_before", notice_led, 1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; send = 1'b0;
        @(negedge clk);
        check("midrst outputs", {request, valid, notice_led, busy, err}, 5'b0);
        check("midrst data_out", data_out, 8'h00);
        n_act = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (request || valid || notice_led || busy) n_act++;
        end
        check("midrst quiet", n_act, 0);

        // Ack glitch while IDLE after a clean transfer of 8'h5A.
        idle(4);
        run_xfer(mk(8'h5A, 2, 3, -1, 8'h00, 4, 3, ONE_SEC, 1'b0), "preglitch");
        idle(2);
        @(posedge clk); #1;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        n_act = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (request || valid || notice_led || busy || err) n_act++;
            @(posedge clk); #1;
        end
        check("glitch quiet", n_act, 0);
        check("glitch data_out", data_out, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
